uart_tx_arbiter: RTL and testbench

Shares the single transmit path of uart_core between NUM_REQ independent byte-stream requesters.
- Round-robin arbitration at message granularity: once granted, a requester keeps the port until its last byte is written, so messages never interleave.
- Drives uart_core's data_in and pulse_tx with the strobe/hold timing that core requires, and honours its tx_full flag.
- Sits between software-visible producers (debug printers, sensor formatters) and uart_core.

---
 rtl/uart_arb_pkg.sv | 25 ++
 rtl/uart_rr_picker.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and sizing helpers for the UART transmit arbiter and its
// round-robin picker.
package uart_arb_pkg;

    // Arbiter FSM states; TAG is only reachable when source tagging is built in.
    typedef enum logic [2:0] {
        IDLE,
        TAG,
        CAPTURE,
        STROBE,
        SETTLE
    } arb_state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int calc_idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int NUM_REQ_DEFAULT = 4;
    localparam int REQ_IDX_W       = calc_idx_w(NUM_REQ_DEFAULT);

    // Mid-message idle counter; 20 bits covers the default 1_000_000 limit.
    localparam int TO_CNT_W = 20;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: selects the first asserted request at or
// after the pointer, wrapping modulo NUM_REQ. Returns one-hot pick and index.
module uart_rr_picker
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = calc_idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_pick,
    output logic [IDX_W-1:0]   o_idx
);

    logic w_found;
    int   w_slot;

    // Scan requesters starting at the pointer and keep the first hit.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path can infer a latch.
        o_pick  = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_slot  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_slot = (int'(i_ptr) + k) % NUM_REQ;
            if (!w_found && i_req[w_slot]) begin
                o_pick[w_slot] = 1'b1;
                o_idx          = IDX_W'(w_slot);
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter in front of uart_core's transmit port.
// Each byte is presented on uart_data_in, strobed once on uart_pulse_tx and
// then held for HOLD_CYCLES so the edge-detecting core can latch it.
// Optional build macro UART_ARB_TAG_EN prefixes every message with the
// zero-extended index of its requester.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_BITS   = 8,
    parameter int HOLD_CYCLES = 2,
    parameter int TIMEOUT     = 1_000_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_last,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         busy,
    output logic                         timeout_err,
    output logic [DATA_BITS-1:0]         uart_data_in,
    output logic                         uart_pulse_tx,
    input  logic                         uart_tx_full
);

    localparam int                    IDX_W     = calc_idx_w(NUM_REQ);
    localparam int                    HOLD_W    = $clog2(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0]     HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [TO_CNT_W-1:0]   TO_LIMIT  = TO_CNT_W'(TIMEOUT);

    arb_state_t             r_state;
    logic [IDX_W-1:0]       r_ptr;
    logic [IDX_W-1:0]       r_gidx;
    logic [NUM_REQ-1:0]     r_grant;
    logic                   r_busy;
    logic [NUM_REQ-1:0]     r_req_ready;
    logic                   r_timeout_err;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_pulse_tx;
    logic                   r_last;
    logic [HOLD_W-1:0]      r_hold;
    logic [TO_CNT_W-1:0]    r_to_cnt;

    logic [NUM_REQ-1:0]     w_pick;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_own_valid;
    logic                   w_own_last;
    logic [DATA_BITS-1:0]   w_own_data;
    logic [IDX_W-1:0]       w_next_ptr;

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_req  (req_valid),
        .i_ptr  (r_ptr),
        .o_pick (w_pick),
        .o_idx  (w_idx)
    );

    // Current owner's request lines and the pointer slot just past it.
    assign w_own_valid = req_valid[r_gidx];
    assign w_own_last  = req_last[r_gidx];
    assign w_own_data  = req_data[int'(r_gidx) * DATA_BITS +: DATA_BITS];
    assign w_next_ptr  = (r_gidx == IDX_W'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_gidx        <= '0;
            r_grant       <= '0;
            r_busy        <= 1'b0;
            r_req_ready   <= '0;
            r_timeout_err <= 1'b0;
            r_data        <= '0;
            r_pulse_tx    <= 1'b0;
            r_last        <= 1'b0;
            r_hold        <= '0;
            r_to_cnt      <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads pre-edge state.
            r_req_ready   <= '0;
            r_timeout_err <= 1'b0;
            r_pulse_tx    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|req_valid) begin
                        r_grant  <= w_pick;
                        r_gidx   <= w_idx;
                        r_busy   <= 1'b1;
                        r_to_cnt <= '0;
`ifdef UART_ARB_TAG_EN
                        r_state  <= TAG;
`else
                        r_state  <= CAPTURE;
`endif
                    end
                end
`ifdef UART_ARB_TAG_EN
                TAG: begin
                    // Source ID goes out as an ordinary byte; no requester handshake.
                    if (!uart_tx_full) begin
                        r_data     <= DATA_BITS'(r_gidx);
                        r_last     <= 1'b0;
                        r_pulse_tx <= 1'b1;
                        r_state    <= STROBE;
                    end
                end
`endif
                CAPTURE: begin
                    if (w_own_valid && !uart_tx_full) begin
                        r_req_ready <= r_grant;
                        r_data      <= w_own_data;
                        r_last      <= w_own_last;
                        r_to_cnt    <= '0;
                        r_pulse_tx  <= 1'b1;
                        r_state     <= STROBE;
                    end else if ((TIMEOUT != 0) && !w_own_valid) begin
                        // Only an absent owner counts; a full core is a legitimate stall.
                        if (r_to_cnt == TO_LIMIT - 1'b1) begin
                            r_timeout_err <= 1'b1;
                            r_grant       <= '0;
                            r_busy        <= 1'b0;
                            r_ptr         <= w_next_ptr;
                            r_to_cnt      <= '0;
                            r_state       <= IDLE;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end
                end
                STROBE: begin
                    r_hold  <= HOLD_LOAD;
                    r_state <= SETTLE;
                end
                SETTLE: begin
                    if (r_hold == '0) begin
                        if (r_last) begin
                            r_grant <= '0;
                            r_busy  <= 1'b0;
                            r_ptr   <= w_next_ptr;
                            r_state <= IDLE;
                        end else begin
                            r_state <= CAPTURE;
                        end
                    end else begin
                        r_hold <= r_hold - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign grant         = r_grant;
    assign busy          = r_busy;
    assign timeout_err   = r_timeout_err;
    assign uart_data_in  = r_data;
    assign uart_pulse_tx = r_pulse_tx;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter. Expected transmit bytes are queued
// as stimulus is issued and popped on every rising edge of uart_pulse_tx.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int NR   = 4;
    localparam int DB   = 8;
    localparam int HOLD = 2;
    localparam int TO   = 12;
`ifdef UART_ARB_TAG_EN
    localparam int TAG_LAT = HOLD + 2;
`else
    localparam int TAG_LAT = 0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_last = '0;
    logic [NR*DB-1:0] req_data = '0;
    logic             uart_tx_full = 1'b0;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    grant;
    logic             busy;
    logic             timeout_err;
    logic [DB-1:0]    uart_data_in;
    logic             uart_pulse_tx;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic       prev_pulse = 1'b0;
    logic [7:0] mon_exp;
    logic [7:0] sb[$];
    int         ready_cyc[NR];

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ     (NR),
        .DATA_BITS   (DB),
        .HOLD_CYCLES (HOLD),
        .TIMEOUT     (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .grant         (grant),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .uart_data_in  (uart_data_in),
        .uart_pulse_tx (uart_pulse_tx),
        .uart_tx_full  (uart_tx_full)
    );

    // Transmit monitor: compare each strobed byte against the scoreboard.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (uart_pulse_tx === 1'b1 && prev_pulse !== 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL strobe_unexpected: got byte %h, none expected", uart_data_in);
            end else begin
                mon_exp = sb.pop_front();
                if (uart_data_in !== mon_exp) begin
                    bad++;
                    $display("FAIL strobe_data: got %h expected %h", uart_data_in, mon_exp);
                end
            end
        end
        if (uart_pulse_tx === 1'b1 && prev_pulse === 1'b1) begin
            total++;
            bad++;
            $display("FAIL strobe_width: pulse_tx high 2 cycles, expected 1");
        end
        prev_pulse = uart_pulse_tx;
        for (int i = 0; i < NR; i++)
            if (req_ready[i] === 1'b1) ready_cyc[i] = cyc;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req_valid = '0;
        req_last = '0;
        uart_tx_full = 1'b0;
        step;
        step;
        rst = 1'b0;
        step;
    endtask

    task automatic expect_msg(input int idx, input int n, input logic [7:0] base);
`ifdef UART_ARB_TAG_EN
        sb.push_back(8'(idx));
`endif
        for (int k = 0; k < n; k++) sb.push_back(base + 8'(k));
    endtask

    task automatic wait_idle;
        bit done = 1'b0;
        for (int n = 0; n < 400 && !done; n++) begin
            if (busy === 1'b0) done = 1'b1;
            else step;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL wait_idle: busy=%b after 400 cycles, expected 0", busy);
        end
    endtask

    task automatic send_msg(input int idx, input int n, input logic [7:0] base,
                            input int gap_at, input int gap_len);
        bit got;
        for (int k = 0; k < n; k++) begin
            if (k == gap_at) repeat (gap_len) step;
            req_valid[idx] = 1'b1;
            req_last[idx]  = (k == n - 1);
            req_data[idx*DB +: DB] = base + 8'(k);
            got = 1'b0;
            for (int c = 0; c < 400 && !got; c++) begin
                step;
                if (req_ready[idx] === 1'b1) got = 1'b1;
            end
            total++;
            if (!got) begin
                bad++;
                $display("FAIL ready_wait: req %0d byte %0d ready=0 after 400 cycles, expected 1", idx, k);
            end
            req_valid[idx] = 1'b0;
            req_last[idx]  = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step;
        step;
        total++;
        if ({req_ready, grant, busy, timeout_err, uart_data_in, uart_pulse_tx} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: ready=%b grant=%b busy=%b terr=%b data=%h pulse=%b, expected all 0",
                     req_ready, grant, busy, timeout_err, uart_data_in, uart_pulse_tx);
        end
        total++;
        if (dut.r_state !== IDLE) begin
            bad++;
            $display("FAIL reset_state: got %0d expected IDLE", dut.r_state);
        end
        rst = 1'b0;
        step;
    endtask

    task automatic test_single;
        do_reset;
        expect_msg(1, 2, 8'h41);
        req_valid[1] = 1'b1;
        req_last[1] = 1'b0;
        req_data[15:8] = 8'h41;
        step;
        total++;
        if (grant !== 4'b0010 || busy !== 1'b1 || req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL single_grant: grant=%b busy=%b ready=%b, expected 0010 1 0000", grant, busy, req_ready);
        end
        repeat (1 + TAG_LAT) step;
        total++;
        if (req_ready !== 4'b0010 || uart_pulse_tx !== 1'b1) begin
            bad++;
            $display("FAIL single_ready1: ready=%b pulse=%b, expected 0010 1", req_ready, uart_pulse_tx);
        end
        req_data[15:8] = 8'h42;
        req_last[1] = 1'b1;
        repeat (3) begin
            step;
            total++;
            if (uart_pulse_tx !== 1'b0) begin
                bad++;
                $display("FAIL single_gap: pulse=%b between strobes, expected 0", uart_pulse_tx);
            end
        end
        step;
        total++;
        if (uart_pulse_tx !== 1'b1 || req_ready !== 4'b0010) begin
            bad++;
            $display("FAIL single_ready2: pulse=%b ready=%b, expected 1 0010", uart_pulse_tx, req_ready);
        end
        req_valid[1] = 1'b0;
        req_last[1] = 1'b0;
        step;
        step;
        total++;
        if (grant !== 4'b0010) begin
            bad++;
            $display("FAIL single_hold_grant: grant=%b during SETTLE, expected 0010", grant);
        end
        step;
        total++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_release: grant=%b busy=%b, expected 0000 0", grant, busy);
        end
        total++;
        if (dut.r_ptr !== 2'd2) begin
            bad++;
            $display("FAIL single_ptr: ptr=%0d expected 2", dut.r_ptr);
        end
    endtask

    task automatic test_contention;
        do_reset;
        expect_msg(0, 1, 8'hA0);
        expect_msg(2, 1, 8'hA2);
        fork
            send_msg(0, 1, 8'hA0, -1, 0);
            send_msg(2, 1, 8'hA2, -1, 0);
        join
        wait_idle;
        total++;
        if (dut.r_ptr !== 2'd3) begin
            bad++;
            $display("FAIL contention_ptr1: ptr=%0d expected 3", dut.r_ptr);
        end
        expect_msg(0, 1, 8'hB0);
        send_msg(0, 1, 8'hB0, -1, 0);
        wait_idle;
        total++;
        if (dut.r_ptr !== 2'd1) begin
            bad++;
            $display("FAIL contention_ptr2: ptr=%0d expected 1", dut.r_ptr);
        end
        expect_msg(2, 1, 8'hC2);
        expect_msg(0, 1, 8'hC0);
        fork
            send_msg(0, 1, 8'hC0, -1, 0);
            send_msg(2, 1, 8'hC2, -1, 0);
        join
        wait_idle;
    endtask

    task automatic test_message_lock;
        do_reset;
        foreach (ready_cyc[i]) ready_cyc[i] = 0;
        expect_msg(0, 3, 8'hD0);
        expect_msg(1, 1, 8'hE1);
        fork
            send_msg(0, 3, 8'hD0, 1, 10);
            send_msg(1, 1, 8'hE1, -1, 0);
        join
        wait_idle;
        total++;
        if (ready_cyc[1] <= ready_cyc[0]) begin
            bad++;
            $display("FAIL lock_order: req1 ready at cycle %0d, expected after req0 last ready at %0d",
                     ready_cyc[1], ready_cyc[0]);
        end
    endtask

    task automatic test_backpressure;
        do_reset;
        uart_tx_full = 1'b1;
        expect_msg(1, 1, 8'hF1);
        req_valid[1] = 1'b1;
        req_last[1] = 1'b1;
        req_data[15:8] = 8'hF1;
        step;
        repeat (20) begin
            step;
            total++;
            if (req_ready !== 4'b0000 || uart_pulse_tx !== 1'b0 || timeout_err !== 1'b0) begin
                bad++;
                $display("FAIL bp_stall: ready=%b pulse=%b terr=%b while full, expected 0000 0 0",
                         req_ready, uart_pulse_tx, timeout_err);
            end
        end
        uart_tx_full = 1'b0;
        step;
        total++;
        if (uart_pulse_tx !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: pulse=%b one cycle after full drops, expected 1", uart_pulse_tx);
        end
`ifdef UART_ARB_TAG_EN
        begin
            bit got = 1'b0;
            for (int c = 0; c < 50 && !got; c++) begin
                step;
                if (req_ready[1] === 1'b1) got = 1'b1;
            end
            total++;
            if (!got) begin
                bad++;
                $display("FAIL bp_ready: ready=0 after tag, expected 1");
            end
        end
`else
        total++;
        if (req_ready !== 4'b0010) begin
            bad++;
            $display("FAIL bp_ready: ready=%b expected 0010", req_ready);
        end
`endif
        req_valid[1] = 1'b0;
        req_last[1] = 1'b0;
        wait_idle;
    endtask

    task automatic test_timeout;
        int hit = -1;
        do_reset;
        expect_msg(3, 1, 8'h33);
        send_msg(3, 2, 8'h33, 1, 1000);
    endtask

    task automatic test_timeout_exact;
        int hit = -1;
        bit got = 1'b0;
        do_reset;
        expect_msg(3, 1, 8'h33);
        req_valid[3] = 1'b1;
        req_last[3] = 1'b0;
        req_data[31:24] = 8'h33;
        for (int c = 0; c < 50 && !got; c++) begin
            step;
            if (req_ready[3] === 1'b1) got = 1'b1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL to_ready: req3 ready=0, expected 1");
        end
        req_valid[3] = 1'b0;
        for (int s = 1; s <= TO + 8 && hit < 0; s++) begin
            step;
            if (timeout_err === 1'b1) hit = s;
        end
        total++;
        if (hit != TO + 3) begin
            bad++;
            $display("FAIL to_latency: timeout_err at cycle %0d after ready, expected %0d", hit, TO + 3);
        end
        total++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL to_release: grant=%b busy=%b, expected 0000 0", grant, busy);
        end
        step;
        total++;
        if (timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL to_width: timeout_err=%b second cycle, expected 0", timeout_err);
        end
        total++;
        if (dut.r_ptr !== 2'd0) begin
            bad++;
            $display("FAIL to_ptr: ptr=%0d expected 0", dut.r_ptr);
        end
    endtask

    task automatic test_reset_mid_strobe;
        bit got = 1'b0;
        do_reset;
`ifdef UART_ARB_TAG_EN
        sb.push_back(8'h01);
`else
        sb.push_back(8'h61);
`endif
        req_valid[1] = 1'b1;
        req_last[1] = 1'b0;
        req_data[15:8] = 8'h61;
        for (int c = 0; c < 50 && !got; c++) begin
            step;
            if (uart_pulse_tx === 1'b1) got = 1'b1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL rst_strobe_wait: pulse=0 after 50 cycles, expected 1");
        end
        rst = 1'b1;
        req_valid = '0;
        step;
        total++;
        if ({req_ready, grant, busy, timeout_err, uart_data_in, uart_pulse_tx} !== '0) begin
            bad++;
            $display("FAIL rst_mid_outputs: ready=%b grant=%b busy=%b terr=%b data=%h pulse=%b, expected all 0",
                     req_ready, grant, busy, timeout_err, uart_data_in, uart_pulse_tx);
        end
        total++;
        if (dut.r_state !== IDLE) begin
            bad++;
            $display("FAIL rst_mid_state: got %0d expected IDLE", dut.r_state);
        end
        rst = 1'b0;
        step;
        total++;
        if (grant !== 4'b0000 || busy !== 1'b0 || uart_pulse_tx !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_after: grant=%b busy=%b pulse=%b, expected 0000 0 0", grant, busy, uart_pulse_tx);
        end
    endtask

`ifdef UART_ARB_TAG_EN
    task automatic test_tag;
        do_reset;
        expect_msg(2, 1, 8'h77);
        send_msg(2, 1, 8'h77, -1, 0);
        wait_idle;
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_contention;
        test_message_lock;
        test_backpressure;
        test_timeout_exact;
        test_reset_mid_strobe;
`ifdef UART_ARB_TAG_EN
        test_tag;
`endif
        repeat (10) step;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d bytes never strobed, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
